uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the baud clock generator; consumes its tx_clk output as a bit-rate strobe.
- Serializes one byte per request as start bit, data LSB first, optional parity, then stop bit(s) onto the serial tx line.
- Runs entirely in the system clk domain. tx_clk is sampled as a level and its rising edge becomes a one-cycle bit tick.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 gives even parity and 1 gives odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- tx_clk  input  1  bit-rate clock from the baud generator, treated as a level in the clk domain.
- newd  input  1  transmit request, one clk cycle wide.
- tx_data  input  DATA_BITS  byte to send, sampled in the cycle newd is accepted.
- tx  output  1  serial line, idle high.
- busy  output  1  high from request acceptance until frame completion.
- donetx  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset values: tx=1, busy=0, donetx=0, state=IDLE, internal tx_clk_d=0, bit and stop counters=0, pending=0.
- Reset at any point, including mid-frame, takes effect at the next clk edge. tx returns to 1, no donetx is produced, and the frame is discarded.
- Bit tick: tick = tx_clk & ~tx_clk_d, with tx_clk_d registered every clk. The bit period equals one full tx_clk period.
- Acceptance rule: newd is accepted only when busy==0.
  - On acceptance, tx_data is latched into the shift register, parity is computed, and busy goes to 1 at the next edge.
  - newd while busy==1 is ignored; there is no queue.
- The frame start aligns to the first tick after acceptance. A tick in the same cycle as acceptance is not used.
- States and transitions (each transition happens only on a tick cycle):
  - IDLE: tx=1. If pending, then tx<=0 and go to START.
  - START: tx<=shift[0], shift right, bitcnt<=0, go to DATA.
  - DATA, when bitcnt==DATA_BITS-1:
    - if PARITY_EN, tx<=parity and go to PARITY;
    - otherwise tx<=1, stopcnt<=0, go to STOP.
  - DATA, otherwise: tx<=shift[0], shift right, bitcnt++.
  - PARITY: tx<=1, stopcnt<=0, go to STOP.
  - STOP, when stopcnt==STOP_BITS-1: go to IDLE with busy<=0, donetx<=1 for one cycle, pending<=0.
  - STOP, otherwise: stopcnt++.
- Parity: even parity is the XOR of all DATA_BITS bits; odd parity is its inverse.
- Latency: the frame occupies 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods, measured from the first tick. donetx fires on tick number 1+DATA_BITS+PARITY_EN+STOP_BITS (ticks counted from 0).
- Back-to-back: newd asserted in the same cycle as donetx is accepted, because busy is already 0 in that cycle. The next start bit begins on the following tick, so there is no idle gap beyond tick alignment.
- tx_clk stuck at a constant level: no ticks occur. The block holds its state indefinitely and busy stays high.
- Counters are sized to $clog2(DATA_BITS) bits. No wrap-around is reachable given the terminal compares.

Test Plan:
- Reset then idle, with tx_clk toggling every 8 clk: tx=1, busy=0, donetx=0 for 200 cycles.
- Default params, newd with tx_data=0x55: sequence per tick is 0,1,0,1,0,1,0,1,0,1, each bit held 16 clk; donetx is one cycle at tick 10; busy falls in the same cycle.
- PARITY_EN=1, PARITY_ODD=0, data 0x07: data bits are 1,1,1,0,0,0,0,0, the parity bit is 1, then stop 1; donetx at tick 11. With PARITY_ODD=1 the parity bit is 0.
- newd with 0xA3, then newd with 0xFF while busy: line shows only 0xA3 (LSB first: 1,1,0,0,0,1,0,1); 0xFF is never transmitted.
- newd with 0x3C asserted in the donetx cycle of a prior frame: the second frame's start bit appears on the next tick and both frames are intact.
- STOP_BITS=2, byte 0x00, rst asserted during data bit 4: tx=1 and busy=0 one clk later, with no donetx.
- A following newd with 0x81 then sends a clean full frame with two stop bits; donetx at tick 11.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Bit timing comes from the rising edge of tx_clk, sampled as a level in the clk domain.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_clk,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 donetx
);

  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] LastBit  = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic                 tx_clk_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [CntW-1:0]      bitcnt_q, bitcnt_d;
  logic [CntW-1:0]      stopcnt_q, stopcnt_d;
  logic                 pending_q, pending_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 accept;

  assign tick   = tx_clk & ~tx_clk_q;
  assign accept = newd & ~busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_clk_q  <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_clk_q  <= tx_clk;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    pending_d = pending_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Acceptance only happens in idle, so it never collides with a tick-driven update.
    if (accept) begin
      shift_d   = tx_data;
      parity_d  = (^tx_data) ^ (PARITY_ODD != 0);
      pending_d = 1'b1;
      busy_d    = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            tx_d    = 1'b0;
            state_d = StStart;
          end
        end
        StStart: begin
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = '0;
          state_d  = StData;
        end
        StData: begin
          if (bitcnt_q == LastBit) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d      = 1'b1;
              stopcnt_d = '0;
              state_d   = StStop;
            end
          end else begin
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + CntW'(1);
          end
        end
        StParity: begin
          tx_d      = 1'b1;
          stopcnt_d = '0;
          state_d   = StStop;
        end
        StStop: begin
          if (stopcnt_q == LastStop) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pending_d = 1'b0;
          end else begin
            stopcnt_d = stopcnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tx     = tx_q;
  assign busy   = busy_q;
  assign donetx = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (default, even parity, odd parity,
// two stop bits) checked against a frame model built from the bit-level frame format.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_clk;
  logic [3:0] newd;
  logic [7:0] tx_data;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  bit         run = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_serializer #(
      .DATA_BITS (8),
      .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .tx_clk (tx_clk),
      .newd   (newd[g]),
      .tx_data(tx_data),
      .tx     (tx_w[g]),
      .busy   (busy_w[g]),
      .donetx (done_w[g])
    );
  end

  initial forever #5 clk = ~clk;

  // tx_clk changes 2 time units after a clk edge so its rise is never ambiguous.
  initial begin
    tx_clk = 1'b0;
    forever begin
      repeat (8) @(posedge clk);
      #2;
      if (run) tx_clk = ~tx_clk;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  function automatic bit cfg_pe(input int d);
    return (d == 1 || d == 2);
  endfunction

  function automatic bit cfg_odd(input int d);
    return (d == 2);
  endfunction

  function automatic int cfg_sb(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return 1 + 8 + int'(cfg_pe(d)) + cfg_sb(d);
  endfunction

  // Line level expected during bit period k of a frame carrying data.
  function automatic logic exp_bit(input int d, input logic [7:0] data, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return data[k-1];
    if (cfg_pe(d) && k == 9) return (^data) ^ cfg_odd(d);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic req(input int d, input logic [7:0] data);
    newd[d] = 1'b1;
    tx_data = data;
  endtask

  // Waits (bounded) for the next tx_clk rise; any pending request is one cycle wide.
  task automatic wait_rise(output bit ok);
    logic prev;
    prev = tx_clk;
    ok   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      newd = '0;
      if (tx_clk && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = tx_clk;
    end
  endtask

  task automatic idle_check(input int d, input int cycles, input string tag);
    bit bad;
    bad = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  // Follows one frame tick by tick. inject_k: issue a newd of 0xFF mid-bit k while busy.
  // rst_k: pulse reset mid-bit k and expect the frame to be dropped. chain: request
  // next_data in the donetx cycle.
  task automatic check_frame(input int d, input logic [7:0] data, input int inject_k,
                             input int rst_k, input bit chain, input logic [7:0] next_data);
    int len;
    bit ok;
    bit bad;
    len = frame_len(d);
    for (int k = 0; k <= len; k++) begin
      wait_rise(ok);
      chk($sformatf("d%0d data%02h k%0d tick_seen", d, data, k), ok, 1'b1);
      if (!ok) return;
      @(negedge clk);
      chk($sformatf("d%0d data%02h k%0d donetx", d, data, k), done_w[d], (k == len));
      chk($sformatf("d%0d data%02h k%0d busy", d, data, k), busy_w[d], (k < len));
      if (k < len) begin
        chk($sformatf("d%0d data%02h k%0d tx_edge", d, data, k), tx_w[d], exp_bit(d, data, k));
        repeat (6) @(negedge clk);
        chk($sformatf("d%0d data%02h k%0d tx_mid", d, data, k), tx_w[d], exp_bit(d, data, k));
        chk($sformatf("d%0d data%02h k%0d done_mid", d, data, k), done_w[d], 1'b0);
        if (k == inject_k) req(d, 8'hFF);
        if (k == rst_k) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk($sformatf("d%0d rst tx", d), tx_w[d], 1'b1);
          chk($sformatf("d%0d rst busy", d), busy_w[d], 1'b0);
          chk($sformatf("d%0d rst donetx", d), done_w[d], 1'b0);
          bad = 1'b0;
          repeat (200) begin
            @(negedge clk);
            if (done_w[d] !== 1'b0 || tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0) bad = 1'b1;
          end
          chk($sformatf("d%0d after_rst quiet", d), bad, 1'b0);
          return;
        end
      end else if (chain) begin
        req(d, next_data);
      end else begin
        @(negedge clk);
        chk($sformatf("d%0d data%02h done_pulse_end", d, data), done_w[d], 1'b0);
        chk($sformatf("d%0d data%02h tx_idle", d, data), tx_w[d], 1'b1);
      end
    end
  endtask

  initial begin
    int         d;
    logic [7:0] data;
    logic [7:0] nd;
    bit         c;
    bit         bad;

    rst     = 1'b1;
    newd    = '0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("d%0d reset tx", g), tx_w[g], 1'b1);
      chk($sformatf("d%0d reset busy", g), busy_w[g], 1'b0);
      chk($sformatf("d%0d reset donetx", g), done_w[g], 1'b0);
    end
    rst = 1'b0;
    for (int g = 0; g < 4; g++) idle_check(g, 50, $sformatf("d%0d idle_after_reset", g));

    // Default frame, alternating pattern.
    @(negedge clk); req(0, 8'h55);
    check_frame(0, 8'h55, -1, -1, 1'b0, 8'h00);

    // Parity even then odd.
    @(negedge clk); req(1, 8'h07);
    check_frame(1, 8'h07, -1, -1, 1'b0, 8'h00);
    @(negedge clk); req(2, 8'h07);
    check_frame(2, 8'h07, -1, -1, 1'b0, 8'h00);

    // Request while busy is dropped, not queued.
    @(negedge clk); req(0, 8'hA3);
    check_frame(0, 8'hA3, 3, -1, 1'b0, 8'h00);
    idle_check(0, 40, "d0 no_queued_frame");

    // Back-to-back request in the donetx cycle.
    @(negedge clk); req(0, 8'hC5);
    check_frame(0, 8'hC5, -1, -1, 1'b1, 8'h3C);
    check_frame(0, 8'h3C, -1, -1, 1'b0, 8'h00);

    // Reset during data bit 4, then a clean two-stop-bit frame.
    @(negedge clk); req(3, 8'h00);
    check_frame(3, 8'h00, -1, 5, 1'b0, 8'h00);
    @(negedge clk); req(3, 8'h81);
    check_frame(3, 8'h81, -1, -1, 1'b0, 8'h00);

    // Stalled tx_clk: request held pending, line idle, busy high.
    run = 1'b0;
    repeat (3) @(negedge clk);
    req(0, 8'h96);
    @(negedge clk);
    newd = '0;
    bad  = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b1 || tx_w[0] !== 1'b1 || done_w[0] !== 1'b0) bad = 1'b1;
    end
    chk("d0 stalled_hold", bad, 1'b0);
    run = 1'b1;
    check_frame(0, 8'h96, -1, -1, 1'b0, 8'h00);

    // Random frames on random configurations, sometimes chained.
    for (int i = 0; i < 12; i++) begin
      d    = int'($urandom_range(0, 3));
      data = 8'($urandom);
      nd   = 8'($urandom);
      c    = 1'($urandom_range(0, 1));
      @(negedge clk); req(d, data);
      check_frame(d, data, -1, -1, c, nd);
      if (c) check_frame(d, nd, -1, -1, 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
